// File: rtl/riscv_types.sv
// Shared types and constants for the rv32imf front end.
package riscv_types;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_BUF,
    KILL,
    HALT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_buf.sv
// One-entry IF/ID output buffer: valid/pc/instr with load, consume and clear.
module fetch_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_consume,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;

  // Clear wins over load so a redirect always drops the word arriving with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_consume) begin
        r_valid <= 1'b0;
      end
      if (i_load && !i_clear) begin
        r_pc    <= i_pc;
        r_instr <= i_instr;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, single-outstanding imem req/ack, redirect with kill.
// Optional FETCH_MISALIGN_CHK_EN adds misalign_o and a HALT state for misaligned targets.
module fetch_ctrl
  import riscv_types::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            misalign_o,
`endif
  output logic            flush_o
);

  fetch_state_t    r_state, w_state_nxt;
  fetch_state_t    w_redir_st, w_kill_st;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_tgt, w_tgt_nxt;
  logic [XLEN-1:0] w_redir_pc, w_buf_pc;
  logic            r_pend, w_pend_nxt;
  logic            w_room, w_consume, w_load;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_redir_pc = redirect_pc_i;
  assign w_redir_st = (|redirect_pc_i[1:0]) ? HALT : FETCH;
  assign w_kill_st  = (|r_tgt[1:0]) ? HALT : FETCH;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc_i[1:0];
  assign w_redir_pc   = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_redir_st   = FETCH;
  assign w_kill_st    = FETCH;
`endif

  assign w_consume  = if_valid_o & ~stall_i;
  // A new request only starts when the buffer can take its response.
  assign w_room     = ~if_valid_o | ~stall_i;
  assign w_pend_nxt = imem_req_o & ~imem_ack_i;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    imem_req_o  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = w_redir_st;
        end else begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        imem_req_o = r_pend | w_room;
        if (redirect_i) begin
          if (imem_req_o && !imem_ack_i) begin
            w_tgt_nxt   = w_redir_pc;
            w_state_nxt = KILL;
          end else begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = w_redir_st;
          end
        end else if (imem_req_o && imem_ack_i) begin
          w_load   = 1'b1;
          w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
        end else if (!imem_req_o) begin
          w_state_nxt = WAIT_BUF;
        end
      end
      WAIT_BUF: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = w_redir_st;
        end else if (w_consume) begin
          w_state_nxt = FETCH;
        end
      end
      KILL: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          w_tgt_nxt = w_redir_pc;
        end else if (imem_ack_i) begin
          w_pc_nxt    = r_tgt;
          w_state_nxt = w_kill_st;
        end
      end
      HALT: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = w_redir_st;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  fetch_buf #(
    .XLEN (XLEN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_consume (w_consume),
    .i_clear   (redirect_i),
    .i_pc      (r_pc),
    .i_instr   (imem_rdata_i),
    .o_valid   (if_valid_o),
    .o_pc      (w_buf_pc),
    .o_instr   (if_instr_o)
  );

  assign imem_addr_o = r_pc;
  assign flush_o     = redirect_i;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_o = (r_state == HALT);
  assign if_pc_o    = (r_state == HALT) ? r_pc : w_buf_pc;
`else
  assign if_pc_o    = w_buf_pc;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized in-order stream model.
module tb_fetch_ctrl;

  logic        clk, reset, stall_i, redirect_i, imem_req_o, imem_ack_i;
  logic        if_valid_o, flush_o;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, if_pc_o, if_instr_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int          n_vec, n_err;
  bit          mem_busy, mem_rand;
  logic [31:0] mem_addr;
  int          mem_cnt, mem_delay;

  fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_o    (misalign_o),
`endif
    .flush_o       (flush_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    mem_busy = 1'b0; mem_rand = 1'b0; mem_delay = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // One cycle: drive inputs at negedge, memory answers req, outputs settle before posedge.
  task automatic step(input bit s, input bit r, input logic [31:0] t, input bit spur);
    @(negedge clk);
    stall_i = s; redirect_i = r; redirect_pc_i = t; imem_ack_i = 1'b0;
    #1;
    if (imem_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr_o;
        mem_cnt  = mem_rand ? int'($urandom_range(3, 0)) : mem_delay;
      end
      if (mem_cnt == 0) begin
        imem_ack_i = 1'b1; imem_rdata_i = mem_f(mem_addr); mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (spur) begin
      imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic test_reset;
    do_reset;
    n_vec++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL reset_req req=%b addr=%h required req=0 addr=0", imem_req_o, imem_addr_o);
    end
    n_vec++;
    if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin
      n_err++; $display("FAIL reset_buf valid=%b pc=%h instr=%h required 0/0/0",
                        if_valid_o, if_pc_o, if_instr_o);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    n_vec++;
    if (misalign_o !== 1'b0) begin
      n_err++; $display("FAIL reset_misalign got=%b required 0", misalign_o);
    end
`endif
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL reset_first_req req=%b addr=%h required req=1 addr=0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p;
    do_reset;
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, 0, 0);
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * (c - 1))) begin
        n_err++; $display("FAIL b2b_req c=%0d req=%b addr=%h required req=1 addr=%h",
                          c, imem_req_o, imem_addr_o, 32'(4 * (c - 1)));
      end
      n_vec++;
      if (c >= 2) begin
        p = 32'(4 * (c - 2));
        if (if_valid_o !== 1'b1 || if_pc_o !== p || if_instr_o !== mem_f(p)) begin
          n_err++; $display("FAIL b2b_buf c=%0d valid=%b pc=%h instr=%h required 1/%h/%h",
                            c, if_valid_o, if_pc_o, if_instr_o, p, mem_f(p));
        end
      end else if (if_valid_o !== 1'b0) begin
        n_err++; $display("FAIL b2b_buf c=%0d valid=%b required 0", c, if_valid_o);
      end
    end
  endtask

  task automatic test_stall;
    do_reset;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int c = 3; c <= 6; c++) begin
      step(c != 6, 0, 0, c == 4);
      n_vec++;
      if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== 32'h4 || if_instr_o !== mem_f(32'h4)) begin
        n_err++; $display("FAIL stall_hold c=%0d req=%b valid=%b pc=%h instr=%h required 0/1/4/%h",
                          c, imem_req_o, if_valid_o, if_pc_o, if_instr_o, mem_f(32'h4));
      end
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || if_valid_o !== 1'b0) begin
      n_err++; $display("FAIL stall_resume req=%b addr=%h valid=%b required 1/8/0",
                        imem_req_o, imem_addr_o, if_valid_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || if_instr_o !== mem_f(32'h8)) begin
      n_err++; $display("FAIL stall_next valid=%b pc=%h instr=%h required 1/8/%h",
                        if_valid_o, if_pc_o, if_instr_o, mem_f(32'h8));
    end
  endtask

  task automatic test_kill;
    do_reset;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    mem_delay = 4;
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    mem_delay = 0;
    n_vec++;
    if (flush_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
      n_err++; $display("FAIL kill_flush flush=%b req=%b addr=%h required 1/1/8", flush_o, imem_req_o, imem_addr_o);
    end
    for (int c = 5; c <= 7; c++) begin
      step(0, 0, 0, 0);
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || if_valid_o !== 1'b0 || flush_o !== 1'b0) begin
        n_err++; $display("FAIL kill_hold c=%0d req=%b addr=%h valid=%b flush=%b required 1/8/0/0",
                          c, imem_req_o, imem_addr_o, if_valid_o, flush_o);
      end
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin
      n_err++; $display("FAIL kill_target req=%b addr=%h valid=%b required 1/100/0", imem_req_o, imem_addr_o, if_valid_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_instr_o !== mem_f(32'h100)) begin
      n_err++; $display("FAIL kill_deliver valid=%b pc=%h required 1/100", if_valid_o, if_pc_o);
    end
  endtask

  task automatic test_redirect_on_ack;
    do_reset;
    step(0, 1, 32'h200, 0);
    n_vec++;
    if (flush_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL rda_flush flush=%b addr=%h required 1/0", flush_o, imem_addr_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200 || if_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rda_req req=%b addr=%h valid=%b required 1/200/0", imem_req_o, imem_addr_o, if_valid_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h200 || if_instr_o !== mem_f(32'h200)) begin
      n_err++; $display("FAIL rda_deliver valid=%b pc=%h required 1/200", if_valid_o, if_pc_o);
    end
  endtask

  task automatic test_double_redirect;
    do_reset;
    step(0, 0, 0, 0);
    mem_delay = 3;
    step(0, 1, 32'h300, 0);
    mem_delay = 0;
    step(0, 1, 32'h400, 0);
    for (int c = 3; c <= 5; c++) begin
      if (c > 3) step(0, 0, 0, 0);
      n_vec++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
        n_err++; $display("FAIL dbl_hold c=%0d req=%b addr=%h required 1/4", c, imem_req_o, imem_addr_o);
      end
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin
      n_err++; $display("FAIL dbl_target req=%b addr=%h required 1/400", imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h400) begin
      n_err++; $display("FAIL dbl_deliver valid=%b pc=%h required 1/400", if_valid_o, if_pc_o);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    step(0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_req addr=%h required fffffffc", imem_addr_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_pc_o !== 32'hFFFF_FFFC || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL wrap_next pc=%h addr=%h required fffffffc/0", if_pc_o, imem_addr_o);
    end
  endtask

  task automatic test_misalign;
    do_reset;
    step(0, 0, 0, 0);
    step(0, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    n_vec++;
    if (misalign_o !== 1'b0) begin
      n_err++; $display("FAIL mis_pre got=%b required 0", misalign_o);
    end
    for (int c = 3; c <= 5; c++) begin
      step(0, 0, 0, 0);
      n_vec++;
      if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || if_pc_o !== 32'h102 || if_valid_o !== 1'b0) begin
        n_err++; $display("FAIL mis_halt c=%0d mis=%b req=%b pc=%h valid=%b required 1/0/102/0",
                          c, misalign_o, imem_req_o, if_pc_o, if_valid_o);
      end
    end
    step(0, 1, 32'h104, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h104) begin
      n_err++; $display("FAIL mis_exit mis=%b req=%b addr=%h required 0/1/104", misalign_o, imem_req_o, imem_addr_o);
    end
    do_reset;
    step(0, 0, 0, 0);
    mem_delay = 2;
    step(0, 1, 32'h106, 0);
    mem_delay = 0;
    step(0, 0, 0, 0);
    n_vec++;
    if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      n_err++; $display("FAIL mis_kill mis=%b req=%b addr=%h required 0/1/4", misalign_o, imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || if_pc_o !== 32'h106) begin
      n_err++; $display("FAIL mis_kill_halt mis=%b req=%b pc=%h required 1/0/106", misalign_o, imem_req_o, if_pc_o);
    end
`else
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      n_err++; $display("FAIL mis_mask req=%b addr=%h required 1/100", imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin
      n_err++; $display("FAIL mis_mask_deliver valid=%b pc=%h required 1/100", if_valid_o, if_pc_o);
    end
`endif
  endtask

  task automatic test_reset_mid_kill;
    do_reset;
    step(0, 0, 0, 0);
    mem_delay = 5;
    step(0, 1, 32'h300, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      n_err++; $display("FAIL rmk_kill req=%b addr=%h required 1/4", imem_req_o, imem_addr_o);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0 || if_pc_o !== 32'h0) begin
      n_err++; $display("FAIL rmk_async req=%b addr=%h valid=%b pc=%h required 0/0/0/0",
                        imem_req_o, imem_addr_o, if_valid_o, if_pc_o);
    end
    do_reset;
    n_vec++;
    if (imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL rmk_idle req=%b required 0", imem_req_o);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL rmk_first req=%b addr=%h required 1/0", imem_req_o, imem_addr_o);
    end
  endtask

  // Program-order model: delivered PCs run +4 from the last redirect target.
  task automatic test_random;
    logic [31:0] exp_pc, t, t_exp, prev_addr;
    bit          prev_pend, prev_redir, s, r, seen;
    int          delivered;
    do_reset;
    mem_rand = 1'b1;
    exp_pc = 32'h0; prev_pend = 1'b0; prev_redir = 1'b0; delivered = 0;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(3, 0) == 0);
      r = ($urandom_range(15, 0) == 0);
      t = $urandom & 32'h0000_3fff;
`ifdef FETCH_MISALIGN_CHK_EN
      t = t & 32'hFFFF_FFFC;
`endif
      t_exp = t & 32'hFFFF_FFFC;
      step(s, r, t, $urandom_range(1, 0) == 1);
      n_vec++;
      if (flush_o !== r) begin
        n_err++; $display("FAIL rnd_flush i=%0d flush=%b required %b", i, flush_o, r);
      end
      if (prev_pend) begin
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
          n_err++; $display("FAIL rnd_handshake i=%0d req=%b addr=%h required 1/%h", i, imem_req_o, imem_addr_o, prev_addr);
        end
      end
      if (prev_redir) begin
        n_vec++;
        if (if_valid_o !== 1'b0) begin
          n_err++; $display("FAIL rnd_postflush i=%0d valid=%b required 0", i, if_valid_o);
        end
      end
      if (r) begin
        exp_pc = t_exp;
      end else if (if_valid_o === 1'b1 && !s) begin
        n_vec++;
        if (if_pc_o !== exp_pc || if_instr_o !== mem_f(exp_pc)) begin
          n_err++; $display("FAIL rnd_stream i=%0d pc=%h instr=%h required %h/%h",
                            i, if_pc_o, if_instr_o, exp_pc, mem_f(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_pend  = imem_req_o && !imem_ack_i;
      prev_addr  = imem_addr_o;
      prev_redir = r;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 0, 0, 0);
      if (if_valid_o === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (if_pc_o !== exp_pc) begin
          n_err++; $display("FAIL rnd_drain pc=%h required %h", if_pc_o, exp_pc);
        end
      end
    end
    n_vec++;
    if (seen !== 1'b1) begin
      n_err++; $display("FAIL rnd_liveness seen=%b required 1 within 40 cycles", seen);
    end
    n_vec++;
    if (delivered < 100) begin
      n_err++; $display("FAIL rnd_throughput delivered=%0d required >=100", delivered);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    mem_busy = 1'b0; mem_rand = 1'b0; mem_delay = 0; mem_addr = '0; mem_cnt = 0;
    test_reset;
    test_back_to_back;
    test_stall;
    test_kill;
    test_redirect_on_ack;
    test_double_redirect;
    test_wrap;
    test_misalign;
    test_reset_mid_kill;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end fetch sequencer for the rv32imf core. It owns the PC and issues single-outstanding requests to instruction memory over a req/ack handshake. It holds fetched instructions in a one-entry output buffer for the IF/ID stage. It applies taken-branch/jump redirects from the branch controller (pc_sel, target), including killing a fetch already in flight.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
stall_i  input  1  IF/ID stage cannot accept an instruction this cycle
redirect_i  input  1  taken branch/jump (pc_sel), single-cycle pulse
redirect_pc_i  input  XLEN  redirect target address
imem_req_o  output  1  fetch request
imem_addr_o  output  XLEN  fetch address
imem_ack_i  input  1  one-cycle response strobe; imem_rdata_i valid with it
imem_rdata_i  input  32  fetched instruction
if_valid_o  output  1  output buffer holds a valid instruction
if_pc_o  output  XLEN  PC of the buffered instruction
if_instr_o  output  32  buffered instruction
flush_o  output  1  flush IF/ID and ID/EX; combinational copy of redirect_i

Behaviour:
- Reset (async, any state, including mid-fetch):
  - state=IDLE, pc_q=RESET_PC.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - if_valid_o=0, if_pc_o=0, if_instr_o=0.
  - A response arriving after reset deassertion for a pre-reset request is not possible; memory is reset together with the core.
- Handshake rules:
  - imem_req_o stays high until imem_ack_i.
  - imem_addr_o is stable while imem_req_o=1.
  - At most one request is outstanding.
  - An ack with imem_req_o=0 is ignored.
- Buffer consume: a consume occurs in any cycle where if_valid_o=1 and stall_i=0.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: imem_req_o=1, imem_addr_o=pc_q.
    - On ack without redirect: buffer <= {pc_q, rdata}, if_valid_o=1 next cycle, pc_q <= pc_q+4 (modulo 2^XLEN, wraps silently).
    - After that ack, go to FETCH if the buffer is empty or consumed this cycle, else WAIT_BUF.
    - Best-case throughput is one instruction per ack with zero bubble cycles.
  - WAIT_BUF: imem_req_o=0; go to FETCH in the cycle after the buffer is consumed.
  - KILL: imem_req_o=1 with the stale address; wait for ack, discard the data, then go to FETCH using the stored target.
- Redirect (priority over stall and ack):
  - flush_o=1 in the same cycle.
  - Next cycle: if_valid_o=0 and pc_q <= redirect_pc_i.
  - If in FETCH without ack in that cycle: go to KILL.
  - If in FETCH with ack in that cycle: discard the data, stay in FETCH, and the next request uses the target.
  - If in WAIT_BUF or IDLE: go to FETCH.
  - If in KILL: overwrite the stored target and stay in KILL.
- Latency: request issues the cycle after entering FETCH; buffered instruction is visible the cycle after the ack.
- Stall with a full buffer holds if_pc_o and if_instr_o unchanged.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined:
  - Adds output port misalign_o (1 bit, reset 0).
  - A redirect target with bits[1:0]!=0 enters state HALT: no request issued, misalign_o=1, if_pc_o=target, if_valid_o=0.
  - HALT exits only on the next redirect or on reset.
  - A misaligned target arriving in KILL is checked after the kill completes.
- Undefined:
  - No port is added.
  - redirect_pc_i[1:0] is forced to 0.

Decomposition:
- riscv_types package: fetch_state_t enum (IDLE, FETCH, WAIT_BUF, KILL, HALT), INSTR_BYTES=4 constant, NOP_INSTR=32'h0000_0013.
- Output buffer is natural as sub-module fetch_buf: valid/pc/instr register with load, consume and clear.

Test Plan:
- Reset, ack 1 cycle after each req, stall_i=0 -> addresses 0,4,8,C; if_valid_o back-to-back with matching pc/instr.
- Ack, then stall_i=1 for 3 cycles -> imem_req_o=0 during stall; buffer holds pc=4; next req to 8 the cycle after the release.
- Redirect to 0x100 two cycles into a fetch of 0x8 with ack delayed 4 cycles -> flush_o=1; req stays at 0x8 until ack; data discarded; next req 0x100; no if_valid_o for 0x8.
- Redirect to 0x200 in the same cycle as ack -> data dropped; next req 0x200.
- Two redirects (0x300 then 0x400) while in KILL -> next req is 0x400 only.
- FETCH_MISALIGN_CHK_EN: redirect to 0x102 -> misalign_o=1, no req; redirect to 0x104 -> misalign_o=0, req 0x104.
- Reset asserted mid-KILL -> req=0, state IDLE, first req RESET_PC.
